// File: rtl/letter_pool.sv
// letter_pool: active-letter store for the falling-letter typing game.
// Captures the generator outputs every SPAWN_FRAMES frames, advances each
// letter once per frame tick, retires letters that are typed (score) or that
// reach BOTTOM (miss), and offers a zero-latency slot readout for the renderer.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   gen_ch/speed/x/y         generator character, speed, start row, column
//   tick                     one-cycle pulse per video frame
//   key_valid, key_ch        one-cycle key strobe and ASCII code
//   rd_idx                   slot selected for readout
//   rd_valid/ch/x/y          combinational readout of slot rd_idx
//   score, miss, game_over   registered game status
//
// Optional: define LETTER_POOL_SPEEDUP_EN to add min(score[15:4],3) to each
// letter's per-frame step.
module letter_pool #(
  parameter int unsigned SLOTS        = 8,
  parameter int unsigned SPAWN_FRAMES = 60,
  parameter int unsigned BOTTOM       = 480,
  parameter int unsigned MAX_MISS     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               gen_ch,
  input  logic [3:0]               gen_speed,
  input  logic [8:0]               gen_x,
  input  logic [9:0]               gen_y,
  input  logic                     tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_ch,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [7:0]               rd_ch,
  output logic [8:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic [15:0]              score,
  output logic [7:0]               miss,
  output logic                     game_over
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_KEY,
    S_OVER
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               pend_q, pend_n;
  logic [7:0]         key_q, key_n;
  logic               valid_q [SLOTS];
  logic               valid_n [SLOTS];
  logic [7:0]         ch_q    [SLOTS];
  logic [7:0]         ch_n    [SLOTS];
  logic [8:0]         x_q     [SLOTS];
  logic [8:0]         x_n     [SLOTS];
  logic [9:0]         y_q     [SLOTS];
  logic [9:0]         y_n     [SLOTS];
  logic [3:0]         spd_q   [SLOTS];
  logic [3:0]         spd_n   [SLOTS];
  logic [15:0]        score_q, score_n;
  logic [7:0]         miss_q, miss_n;
  logic               over_q;
  logic [4:0]         step;
  logic [9:0]         nx;
  logic               found;

  // Per-frame displacement of the slot currently being moved.
`ifdef LETTER_POOL_SPEEDUP_EN
  logic [1:0] level;
  assign level = (score_q[15:4] > 12'd3) ? 2'd3 : score_q[5:4];
  assign step  = 5'(spd_q[idx_q]) + 5'(level);
`else
  assign step  = 5'(spd_q[idx_q]);
`endif

  // Zero-latency readout for the renderer.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_ch     = ch_q[rd_idx];
  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];
  assign score     = score_q;
  assign miss      = miss_q;
  assign game_over = over_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      key_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      over_q  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        valid_q[i] <= 1'b0;
        ch_q[i]    <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        spd_q[i]   <= '0;
      end
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      key_q   <= key_n;
      score_q <= score_n;
      miss_q  <= miss_n;
      over_q  <= (state_n == S_OVER);
      for (int i = 0; i < SLOTS; i++) begin
        valid_q[i] <= valid_n[i];
        ch_q[i]    <= ch_n[i];
        x_q[i]     <= x_n[i];
        y_q[i]     <= y_n[i];
        spd_q[i]   <= spd_n[i];
      end
    end
  end

  // Next-state and slot update logic.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    pend_n  = pend_q;
    key_n   = key_q;
    score_n = score_q;
    miss_n  = miss_q;
    valid_n = valid_q;
    ch_n    = ch_q;
    x_n     = x_q;
    y_n     = y_q;
    spd_n   = spd_q;
    nx      = '0;
    found   = 1'b0;

    // A miss count at the limit pre-empts whatever the sweep was doing.
    if (state_q != S_OVER && miss_q >= 8'(MAX_MISS)) begin
      state_n = S_OVER;
    end else begin
      // Keys arriving mid-sweep are held one deep; later ones are dropped.
      if ((state_q == S_MOVE || state_q == S_SPAWN) && key_valid && !pend_q) begin
        pend_n = 1'b1;
        key_n  = key_ch;
      end

      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_n = S_MOVE;
            idx_n   = '0;
            if (key_valid && !pend_q) begin
              pend_n = 1'b1;
              key_n  = key_ch;
            end
          end else if (pend_q) begin
            state_n = S_KEY;
          end else if (key_valid) begin
            key_n   = key_ch;
            state_n = S_KEY;
          end
        end

        S_MOVE: begin
          if (valid_q[idx_q]) begin
            nx = 10'(x_q[idx_q]) + 10'(step);
            if (nx >= 10'(BOTTOM)) begin
              valid_n[idx_q] = 1'b0;
              if (miss_q != 8'hFF) miss_n = miss_q + 8'd1;
            end else begin
              x_n[idx_q] = nx[8:0];
            end
          end
          if (idx_q == IDX_W'(SLOTS - 1)) begin
            if (cnt_q == CNT_W'(SPAWN_FRAMES - 1)) begin
              cnt_n   = '0;
              state_n = S_SPAWN;
            end else begin
              cnt_n   = cnt_q + CNT_W'(1);
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end

        S_SPAWN: begin
          // Lowest free slot takes the generator outputs; a full pool drops it.
          for (int i = 0; i < SLOTS; i++) begin
            if (!found && !valid_q[i]) begin
              found      = 1'b1;
              valid_n[i] = 1'b1;
              ch_n[i]    = gen_ch;
              x_n[i]     = gen_x;
              y_n[i]     = gen_y;
              spd_n[i]   = (gen_speed == 4'd0) ? 4'd1 : gen_speed;
            end
          end
          state_n = S_IDLE;
        end

        S_KEY: begin
          for (int i = 0; i < SLOTS; i++) begin
            if (!found && valid_q[i] && ch_q[i] == key_q) begin
              found      = 1'b1;
              valid_n[i] = 1'b0;
            end
          end
          if (found && score_q != 16'hFFFF) score_n = score_q + 16'd1;
          // The processed key is consumed; a key arriving now becomes pending.
          pend_n = key_valid;
          if (key_valid) key_n = key_ch;
          state_n = S_IDLE;
        end

        S_OVER: begin
          state_n = S_OVER;
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule
